lse_simd_pipe: RTL and testbench
================================

LSE_SIMD_PIPE -- requirements
Module: lse_simd_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: packed operand width; a multiple of 4, minimum 8.
REQ-002 SHALL have parameter LUT_SIZE, default 16: number of correction entries.
REQ-003 SHALL have parameter LUT_PRECISION, default 10: bits per correction entry.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: an operand token is present.
REQ-007 SHALL have port in_ready, output, 1: the block accepts the token this cycle.
REQ-008 SHALL have port simd_mode, input, 2: lane split. 00 = 1×DATA_WIDTH, 01 = 2×DATA_WIDTH/2, 10 = 4×DATA_WIDTH/4, 11 = reserved.
REQ-009 SHALL have ports x_in and y_in, input, DATA_WIDTH each: packed unsigned lane operands; lane i occupies bits [i*LW +: LW], where LW is the lane width.
REQ-010 SHALL have port lut_table, input, LUT_SIZE×LUT_PRECISION: the correction table; it is static while tokens are in flight.
REQ-011 SHALL have port out_valid, output, 1: a result token is present.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result token.
REQ-013 SHALL have port result, output, DATA_WIDTH: packed lane results, same layout as the inputs.
REQ-014 SHALL have port mode_out, output, 2: the simd_mode captured with the token.
REQ-015 SHALL have port sat_flags, output, 4: per-lane saturation flags; unused lanes read 0.
REQ-016 SHALL have port err, output, 1: the token was issued in the reserved mode.

Function
REQ-017 SHALL accept a token on the rising edge where in_valid && in_ready, and deliver it on the rising edge where out_valid && out_ready.
REQ-018 SHALL implement a 2-stage pipeline: S1 = max, |x−y|, LUT index; S2 = add, saturate. Latency is exactly 2 cycles from acceptance to out_valid when there is no stall.
REQ-019 SHALL register simd_mode with each token in S1 and S2, so a mode change between consecutive tokens needs no drain and has no bubble.
REQ-020 SHALL advance each stage only when the next stage is empty or is being emptied in the same cycle. in_ready = !s1_valid || s1_advance; s1_advance = !s2_valid || out_ready.
REQ-021 SHALL have full throughput of 1 token/cycle while out_ready = 1.
REQ-022 SHALL hold result, mode_out, sat_flags and err stable while out_valid && !out_ready.
REQ-023 SHALL hold a stalled S1 token unchanged and keep in_ready low while both stages are full and out_ready = 0.
REQ-024 SHALL compute each lane as: d = |x−y| (LW bits); corr = (d < LUT_SIZE) ? lut_table[d] : 0; corr_sat = min(corr, 2^LW−1); sum = max(x,y) + corr_sat at LW+1 bits.
REQ-025 SHALL output 2^LW−1 and set that lane's sat_flags bit when sum ≥ 2^LW; otherwise it SHALL output sum[LW−1:0] with the flag cleared.
REQ-026 SHALL complete a simultaneous accept and deliver in the same cycle with no token lost or duplicated.
REQ-027 SHALL pass a reserved-mode (11) token through the pipeline normally, delivering result = 0, sat_flags = 0, err = 1.
REQ-028 SHALL keep lanes independent, with no carry or borrow crossing a lane boundary.

Reset
REQ-029 SHALL, while rst_n = 0, immediately clear s1_valid, s2_valid, out_valid, result, mode_out, sat_flags and err to 0; in_ready reads 1 after reset.
REQ-030 SHALL discard any token in flight when reset asserts mid-operation, and emit no out_valid after release until a new token is accepted.

Verification
REQ-031 SHALL be covered by a directed scenario with LUT[i] = 16−i, LUT_SIZE = 16, DATA_WIDTH = 24, mode 00, x = 100, y = 98: result = 114 after exactly 2 cycles, sat_flags = 0.
REQ-032 SHALL be covered by a directed scenario in mode 10 with lanes 0..3 x = {60,5,10,0}, y = {60,5,3,40}: lane results {63,21,19,40}, sat_flags = 4'b0001.
REQ-033 SHALL be covered by a directed scenario issuing back-to-back tokens in modes 00, 01, 10, 11 with out_ready = 1: four consecutive out_valid cycles, mode_out = 00, 01, 10, 11, and err high only on the fourth.
REQ-034 SHALL be covered by a directed scenario holding out_ready = 0 for 5 cycles with 3 tokens offered: 2 tokens accepted, in_ready low from the 3rd offer, outputs stable; on release, in-order delivery with no loss.
REQ-035 SHALL be covered by a directed scenario in mode 01 with x lanes = {2047, 4095}, y lanes = {2047, 0}: results {2047+16 → 2063, 4095}, sat_flags = 2'b00, no cross-lane carry.
REQ-036 SHALL be covered by a directed scenario asserting rst_n = 0 asynchronously with 2 tokens in flight: out_valid falls immediately, and no result appears after release.

Source files
------------

// File: rtl/lse_simd_pipe.sv
// lse_simd_pipe: per-lane max(x,y) + LUT[|x-y|] with saturation, split 1/2/4 lanes by simd_mode.
// Two stages, 2-cycle latency, 1 token/cycle; valid/ready backpressure holds both stages in place.
module lse_simd_pipe #(
  parameter int DATA_WIDTH    = 24,
  parameter int LUT_SIZE      = 16,
  parameter int LUT_PRECISION = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        simd_mode,
  input  logic [DATA_WIDTH-1:0]             x_in,
  input  logic [DATA_WIDTH-1:0]             y_in,
  input  logic [LUT_SIZE*LUT_PRECISION-1:0] lut_table,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             result,
  output logic [1:0]                        mode_out,
  output logic [3:0]                        sat_flags,
  output logic                              err
);
  logic                  s1_valid, s1_advance, s2_valid;
  logic [1:0]            s1_mode;
  logic [DATA_WIDTH-1:0] s1_max, s1_corr;
  logic [DATA_WIDTH-1:0] s1_max_nxt, s1_corr_nxt, s2_res_nxt;
  logic [3:0]            s2_sf_nxt;

  logic [DATA_WIDTH-1:0] mx_m  [3];
  logic [DATA_WIDTH-1:0] cs_m  [3];
  logic [DATA_WIDTH-1:0] res_m [3];
  logic [3:0]            sf_m  [3];

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign out_valid  = s2_valid;

  // One datapath per lane split; the registered mode picks which one is used.
  for (genvar m = 0; m < 3; m++) begin : g_mode
    localparam int NL = 1 << m;
    localparam int LW = DATA_WIDTH >> m;
    localparam int DW = (LW > 32) ? LW : 32;
    localparam int CW = (LW > LUT_PRECISION) ? LW : LUT_PRECISION;
    logic [DATA_WIDTH-1:0] mx_p, cs_p, res_p;
    logic [3:0]            sf_p;

    for (genvar k = 0; k < NL; k++) begin : g_lane
      logic [LW-1:0]            xa, yb, mx, d, cs;
      logic [DW-1:0]            d_ext;
      logic [CW-1:0]            c_ext;
      logic [LUT_PRECISION-1:0] corr;
      logic [LW:0]              sum;

      assign xa    = x_in[k*LW +: LW];
      assign yb    = y_in[k*LW +: LW];
      assign mx    = (xa >= yb) ? xa : yb;
      assign d     = (xa >= yb) ? xa - yb : yb - xa;
      assign d_ext = DW'(d);

      always_comb begin
        corr = '0;
        for (int i = 0; i < LUT_SIZE; i++)
          if (d_ext == DW'(i)) corr = lut_table[i*LUT_PRECISION +: LUT_PRECISION];
      end

      // Narrow lanes cannot hold a wide table entry; clamp before the add.
      assign c_ext = CW'(corr);
      assign cs    = (c_ext > CW'({LW{1'b1}})) ? {LW{1'b1}} : c_ext[LW-1:0];

      assign mx_p[k*LW +: LW] = mx;
      assign cs_p[k*LW +: LW] = cs;

      assign sum               = {1'b0, s1_max[k*LW +: LW]} + {1'b0, s1_corr[k*LW +: LW]};
      assign res_p[k*LW +: LW] = sum[LW] ? {LW{1'b1}} : sum[LW-1:0];
      assign sf_p[k]           = sum[LW];
    end

    for (genvar k = NL; k < 4; k++) begin : g_unused
      assign sf_p[k] = 1'b0;
    end

    assign mx_m[m]  = mx_p;
    assign cs_m[m]  = cs_p;
    assign res_m[m] = res_p;
    assign sf_m[m]  = sf_p;
  end

  always_comb begin
    s1_max_nxt  = '0;
    s1_corr_nxt = '0;
    case (simd_mode)
      2'b00:   begin s1_max_nxt = mx_m[0]; s1_corr_nxt = cs_m[0]; end
      2'b01:   begin s1_max_nxt = mx_m[1]; s1_corr_nxt = cs_m[1]; end
      2'b10:   begin s1_max_nxt = mx_m[2]; s1_corr_nxt = cs_m[2]; end
      default: ;
    endcase
  end

  // Reserved mode falls through to zero result and zero flags.
  always_comb begin
    s2_res_nxt = '0;
    s2_sf_nxt  = '0;
    case (s1_mode)
      2'b00:   begin s2_res_nxt = res_m[0]; s2_sf_nxt = sf_m[0]; end
      2'b01:   begin s2_res_nxt = res_m[1]; s2_sf_nxt = sf_m[1]; end
      2'b10:   begin s2_res_nxt = res_m[2]; s2_sf_nxt = sf_m[2]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 2'b00;
      s1_max    <= '0;
      s1_corr   <= '0;
      s2_valid  <= 1'b0;
      result    <= '0;
      mode_out  <= 2'b00;
      sat_flags <= 4'b0000;
      err       <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mode <= simd_mode;
          s1_max  <= s1_max_nxt;
          s1_corr <= s1_corr_nxt;
        end
      end
      if (s1_advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result    <= s2_res_nxt;
          mode_out  <= s1_mode;
          sat_flags <= s2_sf_nxt;
          err       <= (s1_mode == 2'b11);
        end
      end
    end
  end
endmodule

// File: tb/tb_lse_simd_pipe.sv
// Scoreboard bench for lse_simd_pipe with directed vectors and hand-computed expectations.
module tb_lse_simd_pipe;
  typedef struct packed {
    logic [23:0] res;
    logic [1:0]  mode;
    logic [3:0]  sf;
    logic        err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [1:0]   simd_mode, mode_out;
  logic [23:0]  x_in, y_in, result;
  logic [159:0] lut_table;
  logic [3:0]   sat_flags;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   del_cyc[$];
  exp_t mon_e;

  lse_simd_pipe #(.DATA_WIDTH(24), .LUT_SIZE(16), .LUT_PRECISION(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .simd_mode(simd_mode), .x_in(x_in), .y_in(y_in), .lut_table(lut_table),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .mode_out(mode_out), .sat_flags(sat_flags), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic exp_t mk(input logic [23:0] r, input logic [1:0] m,
                              input logic [3:0] f, input logic e);
    exp_t t;
    t.res = r; t.mode = m; t.sf = f; t.err = e;
    return t;
  endfunction

  // Monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result",    32'(result),    32'(mon_e.res));
        check("mode_out",  32'(mode_out),  32'(mon_e.mode));
        check("sat_flags", 32'(sat_flags), 32'(mon_e.sf));
        check("err",       32'(err),       32'(mon_e.err));
      end
      del_cyc.push_back(cyc);
    end
  end

  task automatic send(input logic [1:0] m, input logic [23:0] x, input logic [23:0] y,
                      input exp_t e);
    int n = 0;
    logic acc = 1'b0;
    simd_mode = m; x_in = x; y_in = y; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    else sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    exp_t ea;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    simd_mode = 2'b00; x_in = '0; y_in = '0;
    for (int i = 0; i < 16; i++) lut_table[i*10 +: 10] = 10'(16 - i);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_result",    32'(result),    32'd0);
    check("rst_mode_out",  32'(mode_out),  32'd0);
    check("rst_sat_flags", 32'(sat_flags), 32'd0);
    check("rst_err",       32'(err),       32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single token, mode 00: 100 vs 98 -> 100 + LUT[2]=14 -> 114, two-cycle latency
    del_cyc.delete();
    t0 = cyc;
    send(2'b00, 24'd100, 24'd98, mk(24'd114, 2'b00, 4'b0000, 1'b0));
    wait_drain();
    check("latency", (del_cyc.size() == 1) ? 32'(del_cyc[0] - t0) : 32'hFFFFFFFF, 32'd2);

    // Mode 10: lanes {60,5,10,0} vs {60,5,3,40} -> {63 sat, 21, 19, 40}
    send(2'b10, {6'd0, 6'd10, 6'd5, 6'd60}, {6'd40, 6'd3, 6'd5, 6'd60},
         mk({6'd40, 6'd19, 6'd21, 6'd63}, 2'b10, 4'b0001, 1'b0));
    // Mode 01: {2047,4095} vs {2047,0} -> {2063, 4095}, no carry into lane 1
    send(2'b01, {12'd4095, 12'd2047}, {12'd0, 12'd2047},
         mk({12'd4095, 12'd2063}, 2'b01, 4'b0000, 1'b0));
    // Mode 00 saturation at full width
    send(2'b00, 24'hFFFFFF, 24'hFFFFFF, mk(24'hFFFFFF, 2'b00, 4'b0001, 1'b0));
    wait_drain();

    // Back-to-back tokens through all four modes
    del_cyc.delete();
    send(2'b00, 24'd0, 24'd0, mk(24'd16, 2'b00, 4'b0000, 1'b0));
    send(2'b01, {12'd20, 12'd10}, {12'd20, 12'd12},
         mk({12'd36, 12'd26}, 2'b01, 4'b0000, 1'b0));
    send(2'b10, {6'd4, 6'd3, 6'd2, 6'd1}, {6'd4, 6'd3, 6'd2, 6'd1},
         mk({6'd20, 6'd19, 6'd18, 6'd17}, 2'b10, 4'b0000, 1'b0));
    send(2'b11, 24'h123456, 24'h000001, mk(24'd0, 2'b11, 4'b0000, 1'b1));
    wait_drain();
    check("b2b_count", 32'(del_cyc.size()), 32'd4);
    check("b2b_span", (del_cyc.size() == 4) ? 32'(del_cyc[3] - del_cyc[0]) : 32'hFFFFFFFF, 32'd3);

    // Stall: out_ready low for 5 cycles, three tokens offered
    del_cyc.delete();
    out_ready = 1'b0;
    ea = mk(24'd5000, 2'b00, 4'b0000, 1'b0);
    send(2'b00, 24'd1000, 24'd5000, ea);
    send(2'b01, {12'd7, 12'd100}, {12'd7, 12'd90},
         mk({12'd23, 12'd106}, 2'b01, 4'b0000, 1'b0));
    simd_mode = 2'b10; x_in = {6'd0, 6'd0, 6'd0, 6'd63}; y_in = {6'd0, 6'd0, 6'd0, 6'd62};
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_result",    32'(result),    32'(ea.res));
      check("stall_mode_out",  32'(mode_out),  32'(ea.mode));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b10, {6'd0, 6'd0, 6'd0, 6'd63}, {6'd0, 6'd0, 6'd0, 6'd62},
         mk({6'd16, 6'd16, 6'd16, 6'd63}, 2'b10, 4'b0001, 1'b0));
    wait_drain();
    check("stall_delivered", 32'(del_cyc.size()), 32'd3);

    // Asynchronous reset with two tokens in flight
    out_ready = 1'b0;
    send(2'b00, 24'd50, 24'd50, mk(24'd66, 2'b00, 4'b0000, 1'b0));
    send(2'b00, 24'd60, 24'd50, mk(24'd66, 2'b00, 4'b0000, 1'b0));
    #3;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    check("async_rst_result",    32'(result),    32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_no_output", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
